// File: rtl/iterative_divider.sv
// Radix-2 restoring divider: DOUT_W-bit dividend / DIN_W-bit divisor, one quotient bit per clock.
// Define ITERATIVE_DIVIDER_OVF_EN to flag quotients that do not fit in DIN_W bits on ovf_o.
module iterative_divider #(
    parameter int DIN_W  = 8,
    parameter int DOUT_W = 2 * DIN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DOUT_W-1:0] dividend_i,
    input  logic [DIN_W-1:0]  divisor_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DOUT_W-1:0] quotient_o,
    output logic [DIN_W-1:0]  remainder_o,
    output logic              div_by_zero_o,
    output logic              ovf_o
);

    localparam int CNT_W = (DOUT_W > 1) ? $clog2(DOUT_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DOUT_W-1:0] work_q;     // dividend bits shift out of the MSB, quotient bits in at the LSB
    logic [DIN_W:0]    rem_q;
    logic [DIN_W-1:0]  divisor_q;

    logic [DIN_W:0]    rem_sh;
    logic [DIN_W:0]    rem_nxt;
    logic              ge;
    logic [DOUT_W-1:0] work_nxt;

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);

    always_comb begin
        rem_sh   = (rem_q << 1) | {{DIN_W{1'b0}}, work_q[DOUT_W-1]};
        ge       = (rem_sh >= {1'b0, divisor_q});
        rem_nxt  = ge ? (rem_sh - {1'b0, divisor_q}) : rem_sh;
        work_nxt = {work_q[DOUT_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            work_q        <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        work_q    <= dividend_i;
                        divisor_q <= divisor_i;
                        if (divisor_i == '0) begin
                            state_q       <= DONE;
                            quotient_o    <= '1;
                            remainder_o   <= dividend_i[DIN_W-1:0];
                            div_by_zero_o <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CNT_W'(DOUT_W - 1);
                            rem_q   <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_nxt;
                    work_q <= work_nxt;
                    if (cnt_q == '0) begin
                        state_q       <= DONE;
                        quotient_o    <= work_nxt;
                        remainder_o   <= rem_nxt[DIN_W-1:0];
                        div_by_zero_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ITERATIVE_DIVIDER_OVF_EN
    logic load_zero;
    logic calc_last;
    logic ovf_q;

    assign load_zero = (state_q == IDLE) && in_valid_i && (divisor_i == '0);
    assign calc_last = (state_q == CALC) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (load_zero) begin
            ovf_q <= 1'b1;
        end else if (calc_last) begin
            ovf_q <= |work_nxt[DOUT_W-1:DIN_W];
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule
